// File: rtl/button_fsm.sv
// button_fsm: converts a momentary push-button level into a toggling on/off level.
// An optional synchronizer and a consecutive-sample stability filter reject bounce.
module button_fsm #(
    parameter int SYNC_STAGES   = 0,   // 0..3 synchronizer flops ahead of the filter
    parameter int STABLE_CYCLES = 1    // 1..255 consecutive samples to accept a level
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic stateful_button
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic btn_s;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign btn_s = button;
        end else begin : g_sync
            // NOTE: declaration initialisers give the power-up value; rst still clears them.
            logic [SYNC_STAGES-1:0] sync_q = '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                    sync_q[0] <= button;
                end
            end

            assign btn_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_e     state_q = RELEASED;
    logic [7:0] cnt_q   = '0;
    logic       out_q   = 1'b0;

    // cnt_q holds the number of consecutive samples that differed from the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            unique case (state_q)
                RELEASED: begin
                    if (btn_s) begin
                        if (CNT_LAST == 8'd0) begin
                            state_q <= PRESSED;
                            out_q   <= ~out_q;
                        end else begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= 8'd1;
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        out_q   <= ~out_q;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                PRESSED: begin
                    if (!btn_s) begin
                        if (CNT_LAST == 8'd0) begin
                            state_q <= RELEASED;
                        end else begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= 8'd1;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign stateful_button = out_q;

endmodule

// File: tb/tb_button_fsm.sv
// tb_button_fsm: scoreboard bench for button_fsm in three configurations
// (defaults, STABLE_CYCLES=3, SYNC_STAGES=2) sharing one clock and reset.
module tb_button_fsm;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic btn0 = 1'b0;
    logic btn3 = 1'b0;
    logic btn2 = 1'b0;
    logic out0;
    logic out3;
    logic out2;

    always #5 clk = ~clk;

    button_fsm u_def (
        .clk             (clk),
        .rst             (rst),
        .button          (btn0),
        .stateful_button (out0)
    );

    button_fsm #(.STABLE_CYCLES(3)) u_stab3 (
        .clk             (clk),
        .rst             (rst),
        .button          (btn3),
        .stateful_button (out3)
    );

    button_fsm #(.SYNC_STAGES(2)) u_sync2 (
        .clk             (clk),
        .rst             (rst),
        .button          (btn2),
        .stateful_button (out2)
    );

    typedef struct {
        string       tag;
        int unsigned dut;
        logic        exp;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    function automatic logic dut_out(input int unsigned d);
        case (d)
            0:       return out0;
            1:       return out3;
            default: return out2;
        endcase
    endfunction

    task automatic set_btn(input int unsigned d, input logic b);
        case (d)
            0:       btn0 = b;
            1:       btn3 = b;
            default: btn2 = b;
        endcase
    endtask

    task automatic push_exp(input string tag, input int unsigned d, input logic exp);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pop everything expected at this edge, sampling #1 after the posedge.
    task automatic drain_after_edge();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) check("sb_underflow", 1'b0, 1'b1);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.tag, dut_out(e.dut), e.exp);
        end
    endtask

    task automatic step(input int unsigned d, input logic b, input logic r,
                        input logic exp, input string tag);
        @(negedge clk);
        rst = r;
        set_btn(d, b);
        push_exp(tag, d, exp);
        drain_after_edge();
    endtask

    // Bits are listed first-sample-first, i.e. MSB of the n-bit field first.
    task automatic run_seq(input int unsigned d, input string tag,
                           input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = 0; i < n; i++) begin
            step(d, bits[n-1-i], 1'b0, exps[n-1-i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        btn0 = 1'b0;
        btn3 = 1'b0;
        btn2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        push_exp("rst_def", 0, 1'b0);
        push_exp("rst_stab3", 1, 1'b0);
        push_exp("rst_sync2", 2, 1'b0);
        drain_after_edge();
    endtask

    initial begin
        // Reset held with button pressed, then released while still pressed.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst  = 1'b1;
            btn0 = 1'b1;
            push_exp($sformatf("rst_hold[%0d]", i), 0, 1'b0);
            drain_after_edge();
        end
        run_seq(0, "rst_release", 16'b11111, 16'b11111, 5);

        do_reset();
        run_seq(0, "single", 16'b011100, 16'b011111, 6);

        do_reset();
        run_seq(0, "repeat", 16'b010101, 16'b011001, 6);

        // Sub-cycle bounce settling low: invisible at the edge, output never moves.
        do_reset();
        step(0, 1'b0, 1'b0, 1'b0, "bounce_pre");
        @(negedge clk);
        check("bounce_negedge", out0, 1'b0);
        #1 btn0 = 1'b1;
        #1 btn0 = 1'b0;
        #1 btn0 = 1'b1;
        check("bounce_mid", out0, 1'b0);
        #1 btn0 = 1'b0;
        check("bounce_low", out0, 1'b0);
        push_exp("bounce_edge", 0, 1'b0);
        drain_after_edge();
        #3 check("bounce_high", out0, 1'b0);
        @(negedge clk);
        check("bounce_negedge2", out0, 1'b0);

        // Bounce settling high counts as a single sample of 1.
        #1 btn0 = 1'b1;
        #1 btn0 = 1'b0;
        #1 btn0 = 1'b1;
        push_exp("bounce_hi_edge", 0, 1'b1);
        drain_after_edge();
        step(0, 1'b1, 1'b0, 1'b1, "bounce_hi_hold");

        // Stability filter: aborted press, accepted press, release, second press.
        do_reset();
        run_seq(1, "stab3", 16'b0110111, 16'b0000001, 7);
        run_seq(1, "stab3_cont", 16'b11000111, 16'b11111110, 8);
        run_seq(1, "stab3_abort_rel", 16'b001111, 16'b000000, 6);

        // Two-stage synchronizer: toggle two edges after the first high sample.
        do_reset();
        run_seq(2, "sync2", 16'b0001111, 16'b0000011, 7);
        run_seq(2, "sync2_again", 16'b00001111, 16'b11111100, 8);

        // Reset mid-press: the next edge after release is a fresh press.
        do_reset();
        run_seq(0, "mid_a", 16'b11, 16'b11, 2);
        @(negedge clk);
        rst = 1'b1;
        push_exp("mid_rst", 0, 1'b0);
        drain_after_edge();
        run_seq(0, "mid_b", 16'b110, 16'b111, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
